// File: rtl/fifo_frame_packer.sv
// fifo_frame_packer: drains a standard-mode byte FIFO and wraps the bytes in
// a frame (SYNC0, SYNC1, length, payload, 8-bit additive checksum) on a
// valid/ready byte stream. A frame starts when a full payload is buffered or
// when a partial payload has waited TIMEOUT cycles.
module fifo_frame_packer #(
   parameter int         DEPTH     = 10,
   parameter int         FRAME_LEN = 32,
   parameter int         TIMEOUT   = 1000,
   parameter logic [7:0] SYNC0     = 8'hEB,
   parameter logic [7:0] SYNC1     = 8'h90
) (
   input  logic             clk_sys,
   input  logic             rst,
   output logic             fifo_rd_en,
   input  logic [7:0]       fifo_rd_data,
   input  logic             fifo_valid,
   input  logic             fifo_empty,
   input  logic [DEPTH-1:0] fifo_rd_cnt,
   output logic [7:0]       tx_data,
   output logic             tx_valid,
   input  logic             tx_ready,
   output logic             busy,
   output logic             frame_done,
   output logic [15:0]      frame_cnt
);

   localparam int               TW          = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0]    TIMEOUT_V   = TW'(TIMEOUT);
   localparam logic [DEPTH-1:0] FRAME_LEN_V = DEPTH'(FRAME_LEN);
   localparam logic [7:0]       FRAME_LEN_B = 8'(FRAME_LEN);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC0,
      ST_SYNC1,
      ST_LEN,
      ST_RD_REQ,
      ST_RD_WAIT,
      ST_PAY,
      ST_CSUM
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [TW-1:0] timer;
   logic [7:0]    len_q;
   logic [7:0]    remain_q;
   logic [7:0]    csum_q;
   logic [7:0]    pay_q;
   logic          start_full;
   logic          start_tmo;
   logic          xfer;

   // A byte moves on any edge where the stream is offered and accepted.
   assign xfer = tx_valid & tx_ready;
   assign busy = (state != ST_IDLE);

   // State register.
   always_ff @(posedge clk_sys or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples the pre-edge values, independent of block ordering.
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode and stream outputs; tx_valid/tx_data depend only on
   // state and registers, never on tx_ready.
   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      state_nxt  = state;
      tx_valid   = 1'b0;
      tx_data    = 8'h00;
      start_full = 1'b0;
      start_tmo  = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (fifo_rd_cnt >= FRAME_LEN_V) begin
               start_full = 1'b1;
               state_nxt  = ST_SYNC0;
            end else if (timer == TIMEOUT_V && fifo_rd_cnt != '0) begin
               start_tmo = 1'b1;
               state_nxt = ST_SYNC0;
            end
         end
         ST_SYNC0: begin
            tx_valid = 1'b1;
            tx_data  = SYNC0;
            if (tx_ready) state_nxt = ST_SYNC1;
         end
         ST_SYNC1: begin
            tx_valid = 1'b1;
            tx_data  = SYNC1;
            if (tx_ready) state_nxt = ST_LEN;
         end
         ST_LEN: begin
            tx_valid = 1'b1;
            tx_data  = len_q;
            if (tx_ready) state_nxt = ST_RD_REQ;
         end
         ST_RD_REQ: state_nxt = ST_RD_WAIT;
         ST_RD_WAIT: begin
            if (fifo_valid) state_nxt = ST_PAY;
         end
         ST_PAY: begin
            tx_valid = 1'b1;
            tx_data  = pay_q;
            if (tx_ready) state_nxt = (remain_q == 8'd1) ? ST_CSUM : ST_RD_REQ;
         end
         ST_CSUM: begin
            tx_valid = 1'b1;
            tx_data  = csum_q;
            if (tx_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Read strobe is registered and high exactly for the RD_REQ cycle.
   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) fifo_rd_en <= 1'b0;
      else     fifo_rd_en <= (state_nxt == ST_RD_REQ);
   end

   // Idle timer: counts non-empty idle cycles, saturates, clears otherwise.
   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst)                                          timer <= '0;
      else if (state != ST_IDLE || state_nxt != ST_IDLE) timer <= '0;
      else if (fifo_empty)                              timer <= '0;
      else if (timer != TIMEOUT_V)                      timer <= timer + TW'(1);
   end

   // Frame datapath: length snapshot, byte countdown, payload byte, checksum.
   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         len_q    <= 8'h00;
         remain_q <= 8'h00;
         csum_q   <= 8'h00;
         pay_q    <= 8'h00;
      end else begin
         if (start_full)     len_q <= FRAME_LEN_B;
         else if (start_tmo) len_q <= fifo_rd_cnt[7:0];
         if (state == ST_LEN && xfer) begin
            csum_q   <= len_q;
            remain_q <= len_q;
         end
         if (state == ST_RD_WAIT && fifo_valid) pay_q <= fifo_rd_data;
         if (state == ST_PAY && xfer) begin
            csum_q   <= csum_q + pay_q;
            remain_q <= remain_q - 8'd1;
         end
      end
   end

   // Completion pulse and wrapping frame counter.
   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         frame_done <= 1'b0;
         frame_cnt  <= 16'h0000;
      end else begin
         frame_done <= (state == ST_CSUM) && xfer;
         if (state == ST_CSUM && xfer) frame_cnt <= frame_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_fifo_frame_packer.sv
// Testbench for fifo_frame_packer: a queue-based FIFO model feeds the DUT, a
// monitor captures every transferred byte, and frames are parsed and checked
// against the bytes written into the FIFO.
module tb_fifo_frame_packer;

   localparam int DEPTH     = 10;
   localparam int FRAME_LEN = 32;
   localparam int TIMEOUT   = 50;

   logic             clk_sys = 1'b0;
   logic             rst;
   logic             fifo_rd_en;
   logic [7:0]       fifo_rd_data = 8'h00;
   logic             fifo_valid = 1'b0;
   logic             fifo_empty = 1'b1;
   logic [DEPTH-1:0] fifo_rd_cnt = '0;
   logic [7:0]       tx_data;
   logic             tx_valid;
   logic             tx_ready = 1'b1;
   logic             busy;
   logic             frame_done;
   logic [15:0]      frame_cnt;

   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       fifo_clr = 1'b0;

   logic [7:0] fq[$];       // FIFO contents
   logic [7:0] wr_hist[$];  // bytes written, not yet seen in a frame
   logic [7:0] out_q[$];    // bytes accepted from the DUT stream

   int n_checks = 0;
   int n_errors = 0;
   int exp_frames = 0;
   int done_seen = 0;
   int rd_pulses = 0;
   int rd_empty_viol = 0;
   int payload_total = 0;
   int stream_pos = 0;
   int hold_cnt = 0;
   int ready_mode = 0;
   bit hold_csum = 1'b0;
   logic       prev_valid = 1'b0;
   logic       prev_ready = 1'b0;
   logic [7:0] prev_data = 8'h00;

   typedef struct {
      string      name;
      int         n;
      logic [7:0] first;
      logic [7:0] step;
      int         exp_len;
      int         exp_csum;
   } vec_t;

   vec_t vecs[4];

   fifo_frame_packer #(
      .DEPTH(DEPTH),
      .FRAME_LEN(FRAME_LEN),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk_sys(clk_sys),
      .rst(rst),
      .fifo_rd_en(fifo_rd_en),
      .fifo_rd_data(fifo_rd_data),
      .fifo_valid(fifo_valid),
      .fifo_empty(fifo_empty),
      .fifo_rd_cnt(fifo_rd_cnt),
      .tx_data(tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .busy(busy),
      .frame_done(frame_done),
      .frame_cnt(frame_cnt)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Standard-mode FIFO: read data appears one cycle after rd_en is sampled.
   always @(posedge clk_sys) begin
      fifo_valid <= 1'b0;
      if (fifo_clr) fq.delete();
      else begin
         if (fifo_rd_en && fq.size() != 0) begin
            fifo_rd_data <= fq.pop_front();
            fifo_valid   <= 1'b1;
         end
         if (wr_en) fq.push_back(wr_data);
      end
      fifo_rd_cnt <= DEPTH'(fq.size());
      fifo_empty  <= (fq.size() == 0);
   end

   // Sink ready pattern: always, toggling (optionally stalling the checksum), random.
   always @(posedge clk_sys) begin
      #1;
      case (ready_mode)
         0: tx_ready = 1'b1;
         1: begin
            if (hold_csum && stream_pos == FRAME_LEN + 3 && hold_cnt < 5) begin
               tx_ready = 1'b0;
               hold_cnt++;
            end else begin
               tx_ready = ~tx_ready;
            end
         end
         default: tx_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Stream monitor and protocol checks, sampled mid-cycle.
   always @(negedge clk_sys) begin
      if (rst === 1'b1) begin
         prev_valid = 1'b0;
      end else begin
         if (prev_valid && !prev_ready) begin
            check("stall_valid", 32'(tx_valid), 1);
            check("stall_data", 32'(tx_data), 32'(prev_data));
         end
         if (tx_valid && tx_ready) begin
            out_q.push_back(tx_data);
            stream_pos++;
         end
         if (frame_done) done_seen++;
         if (fifo_rd_en) begin
            rd_pulses++;
            if (fifo_empty) rd_empty_viol++;
         end
         prev_valid = tx_valid;
         prev_ready = tx_ready;
         prev_data  = tx_data;
      end
   end

   task automatic write_bytes(input int n, input logic [7:0] first, input logic [7:0] step);
      logic [7:0] b;
      b = first;
      for (int i = 0; i < n; i++) begin
         @(negedge clk_sys);
         wr_en   = 1'b1;
         wr_data = b;
         wr_hist.push_back(b);
         b = b + step;
      end
      @(negedge clk_sys);
      wr_en = 1'b0;
   endtask

   task automatic write_random(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk_sys);
         if ($urandom_range(0, 3) == 0) begin
            wr_en = 1'b0;
            repeat (int'($urandom_range(1, 20))) @(negedge clk_sys);
         end
         wr_en   = 1'b1;
         wr_data = 8'($urandom);
         wr_hist.push_back(wr_data);
      end
      @(negedge clk_sys);
      wr_en = 1'b0;
   endtask

   task automatic wait_frames(input string tag, input int target, input int budget);
      int k;
      k = 0;
      while (int'(frame_cnt) != target && k < budget) begin
         @(negedge clk_sys);
         k++;
      end
      check({tag, "_frame_wait"}, 32'(k < budget), 1);
      @(negedge clk_sys);
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int k;
      int quiet;
      k = 0;
      quiet = 0;
      while (quiet < 3 && k < budget) begin
         @(negedge clk_sys);
         k++;
         if (fifo_empty && !busy && !wr_en) quiet++;
         else quiet = 0;
      end
      check({tag, "_drain"}, 32'(k < budget), 1);
   endtask

   // Parses one frame from the captured stream and checks it against the
   // oldest written bytes; exp_len/exp_csum < 0 means "model only".
   task automatic check_frame(input string tag, input int exp_len, input int exp_csum);
      logic [7:0] len;
      logic [7:0] sum;
      logic [7:0] b;
      logic [7:0] want;
      check({tag, "_hdr_avail"}, 32'(out_q.size() >= 3), 1);
      if (out_q.size() < 3) return;
      b = out_q.pop_front();
      check({tag, "_sync0"}, 32'(b), 32'hEB);
      b = out_q.pop_front();
      check({tag, "_sync1"}, 32'(b), 32'h90);
      len = out_q.pop_front();
      if (exp_len >= 0) check({tag, "_len"}, 32'(len), exp_len);
      else check({tag, "_len_range"}, 32'(len >= 8'd1 && int'(len) <= FRAME_LEN), 1);
      check({tag, "_body_avail"}, 32'(out_q.size() >= int'(len) + 1), 1);
      if (out_q.size() < int'(len) + 1) return;
      sum = len;
      for (int i = 0; i < int'(len); i++) begin
         b = out_q.pop_front();
         if (wr_hist.size() == 0) begin
            check({tag, "_pay_unwritten"}, 32'(wr_hist.size() != 0), 1);
            return;
         end
         want = wr_hist.pop_front();
         check({tag, "_pay"}, 32'(b), 32'(want));
         sum = sum + want;
      end
      b = out_q.pop_front();
      check({tag, "_csum"}, 32'(b), 32'(sum));
      if (exp_csum >= 0) check({tag, "_csum_value"}, 32'(b), exp_csum);
      payload_total += int'(len);
      exp_frames++;
   endtask

   task automatic check_counts(input string tag);
      check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_frames));
      check({tag, "_done_pulses"}, 32'(done_seen), 32'(exp_frames));
   endtask

   initial begin
      int bad;
      int k;
      bit found;
      int target;

      vecs[0] = '{name: "full32",  n: 32, first: 8'h01, step: 8'h01, exp_len: 32, exp_csum: 'h30};
      vecs[1] = '{name: "short3",  n: 3,  first: 8'hAA, step: 8'h11, exp_len: 3,  exp_csum: 'h34};
      vecs[2] = '{name: "single",  n: 1,  first: 8'h7F, step: 8'h00, exp_len: 1,  exp_csum: 'h80};
      vecs[3] = '{name: "wrap_ff", n: 5,  first: 8'hFF, step: 8'h00, exp_len: 5,  exp_csum: 'h00};

      rst = 1'b1;
      repeat (3) @(negedge clk_sys);
      check("rst_rd_en", 32'(fifo_rd_en), 0);
      check("rst_tx_valid", 32'(tx_valid), 0);
      check("rst_tx_data", 32'(tx_data), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_frame_done", 32'(frame_done), 0);
      check("rst_frame_cnt", 32'(frame_cnt), 0);
      rst = 1'b0;

      // Empty FIFO for a long stretch: nothing may happen.
      bad = 0;
      repeat (10 * TIMEOUT) begin
         @(negedge clk_sys);
         if (fifo_rd_en || tx_valid || busy) bad++;
      end
      check("idle_quiet", 32'(bad), 0);

      // Directed frames, full-length and timeout-flushed.
      foreach (vecs[v]) begin
         write_bytes(vecs[v].n, vecs[v].first, vecs[v].step);
         if (vecs[v].n < FRAME_LEN) begin
            repeat (TIMEOUT - 5) @(negedge clk_sys);
            check({vecs[v].name, "_no_early_frame"}, 32'(busy), 0);
            check({vecs[v].name, "_no_early_bytes"}, 32'(out_q.size()), 0);
         end
         wait_frames(vecs[v].name, exp_frames + 1, 4000);
         check_frame(vecs[v].name, vecs[v].exp_len, vecs[v].exp_csum);
         check_counts(vecs[v].name);
         wait_drain(vecs[v].name, 2000);
      end

      // Toggling ready with a 5-cycle stall on the checksum.
      stream_pos = 0;
      hold_cnt   = 0;
      hold_csum  = 1'b1;
      ready_mode = 1;
      write_bytes(32, 8'h01, 8'h01);
      wait_frames("toggle", exp_frames + 1, 4000);
      check_frame("toggle", 32, 'h30);
      check("toggle_csum_hold", 32'(hold_cnt), 5);
      check_counts("toggle");
      ready_mode = 0;
      hold_csum  = 1'b0;
      wait_drain("toggle", 2000);

      // 40 bytes back-to-back: one full frame, then an 8-byte timeout frame.
      target = exp_frames + 2;
      write_bytes(40, 8'h40, 8'h01);
      wait_frames("b40", target, 4000);
      check_frame("b40_first", 32, -1);
      check_frame("b40_second", 8, -1);
      check_counts("b40");
      wait_drain("b40", 2000);

      // Random bursts with random sink back-pressure.
      ready_mode = 2;
      for (int r = 0; r < 6; r++) begin
         write_random(int'($urandom_range(1, 45)));
         wait_drain("rnd", 6000);
         while (out_q.size() != 0) check_frame("rnd", -1, -1);
         check_counts("rnd");
      end
      ready_mode = 0;
      check("rd_no_empty_read", 32'(rd_empty_viol), 0);
      check("rd_pulses_vs_payload", 32'(rd_pulses), 32'(payload_total));

      // Reset while payload byte 5 is on the stream.
      write_bytes(32, 8'h01, 8'h01);
      k = 0;
      found = 1'b0;
      while (!found && k < 2000) begin
         @(negedge clk_sys);
         k++;
         if (tx_valid && tx_data == 8'h05) found = 1'b1;
      end
      check("rst_reach_pay5", 32'(found), 1);
      #2 rst = 1'b1;
      #1;
      check("midrst_tx_valid", 32'(tx_valid), 0);
      check("midrst_rd_en", 32'(fifo_rd_en), 0);
      check("midrst_busy", 32'(busy), 0);
      check("midrst_frame_cnt", 32'(frame_cnt), 0);
      fifo_clr = 1'b1;
      repeat (3) @(negedge clk_sys);
      out_q.delete();
      wr_hist.delete();
      exp_frames    = 0;
      done_seen     = 0;
      rd_pulses     = 0;
      payload_total = 0;
      fifo_clr = 1'b0;
      rst      = 1'b0;
      write_bytes(32, 8'h80, 8'h03);
      wait_frames("post_rst", 1, 4000);
      check_frame("post_rst", 32, 'hF0);
      check_counts("post_rst");
      wait_drain("post_rst", 2000);
      check("post_rst_rd_pulses", 32'(rd_pulses), 32'(payload_total));
      check("final_no_empty_read", 32'(rd_empty_viol), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
